// File: rtl/flasher_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flasher_pkg
// Purpose  : Shared FSM state encoding and default parameters for flasher_ctrl.
// Revision : 1.0
// ============================================================================
package flasher_pkg;

    localparam int unsigned c_DEB_LEN   = 4;
    localparam int unsigned c_ARM_STEPS = 4;
    localparam int unsigned c_CNT_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : 2-flop synchronizer, level debouncer and rising-edge pulse.
// Revision : 1.0
// ============================================================================
module btn_debounce
    import flasher_pkg::*;
#(
    parameter int unsigned DEB_LEN = c_DEB_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic flick_req
);

    localparam int unsigned c_CW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;

    logic            sync1_q;
    logic            sync2_q;
    logic            btn_db_q;
    logic            db_prev_q;
    logic [c_CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            btn_db_q  <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= btn_in;
            sync2_q   <= sync1_q;
            db_prev_q <= btn_db_q;
            // cnt_q holds how many consecutive samples already disagreed
            if (sync2_q == btn_db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == c_CW'(DEB_LEN - 1)) begin
                btn_db_q <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign flick_req = btn_db_q & ~db_prev_q;

endmodule
`default_nettype wire

// File: rtl/flasher_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : flasher_ctrl
// Purpose  : Button-driven step pacing and sequence supervision for a flasher.
// Revision : 1.0
// ============================================================================
module flasher_ctrl
    import flasher_pkg::*;
#(
    parameter int unsigned DEB_LEN   = c_DEB_LEN,
    parameter int unsigned ARM_STEPS = c_ARM_STEPS,
    parameter int unsigned CNT_W     = c_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_in,
    input  logic [7:0]       presc_div,
    input  logic             dp_busy,
    output logic             step_en,
    output logic             flick,
    output logic [CNT_W-1:0] run_cnt,
    output logic             arm_err,
    output logic [1:0]       state
);

    localparam int unsigned c_AW = (ARM_STEPS > 1) ? $clog2(ARM_STEPS) : 1;

    logic             flick_req;
    state_e           state_q;
    logic [7:0]       div_q;
    logic [7:0]       presc_q;
    logic [7:0]       presc_d;
    logic [c_AW-1:0]  arm_cnt_q;
    logic             flick_q;
    logic             flick_d;
    logic [CNT_W-1:0] run_cnt_q;
    logic             arm_err_q;
    logic             active;

    btn_debounce #(
        .DEB_LEN (DEB_LEN)
    ) u_deb (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .flick_req (flick_req)
    );

    always_comb begin
        active  = (state_q == ST_ARM) || (state_q == ST_RUN);
        step_en = active && (presc_q == div_q);
        presc_d = '0;
        if (active && !step_en) begin
            presc_d = presc_q + 8'd1;
        end
        // a new request beats the consuming step so the flick survives one more period
        flick_d = flick_q;
        if (flick_req && (state_q != ST_DONE)) begin
            flick_d = 1'b1;
        end else if (step_en && flick_q) begin
            flick_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            presc_q   <= '0;
            arm_cnt_q <= '0;
            flick_q   <= 1'b0;
            run_cnt_q <= '0;
            arm_err_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            flick_q <= flick_d;
            case (state_q)
                ST_IDLE: begin
                    if (flick_req) begin
                        state_q   <= ST_ARM;
                        div_q     <= presc_div;
                        arm_cnt_q <= '0;
                    end
                end
                ST_ARM: begin
                    if (dp_busy) begin
                        state_q   <= ST_RUN;
                        arm_err_q <= 1'b0;
                    end else if (step_en) begin
                        if (arm_cnt_q == c_AW'(ARM_STEPS - 1)) begin
                            state_q   <= ST_IDLE;
                            arm_err_q <= 1'b1;
                        end else begin
                            arm_cnt_q <= arm_cnt_q + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!dp_busy) begin
                        state_q <= ST_DONE;
                        presc_q <= '0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    if (run_cnt_q != {CNT_W{1'b1}}) begin
                        run_cnt_q <= run_cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign flick   = flick_q;
    assign run_cnt = run_cnt_q;
    assign arm_err = arm_err_q;
    assign state   = state_q;

endmodule
`default_nettype wire

// File: doc/flasher_ctrl.md
FLASHER_CTRL -- requirements
Module: flasher_ctrl

Interface
REQ-001 Parameter DEB_LEN, 4: consecutive equal synchronized samples required to accept a button level change.
REQ-002 Parameter ARM_STEPS, 4: step_en pulses allowed in ARM for dp_busy to rise before timeout.
REQ-003 Parameter CNT_W, 8: width of run_cnt.
REQ-004 clk  in  1  single system clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 btn_in  in  1  raw flick push-button, asynchronous to clk, bouncy.
REQ-007 presc_div  in  8  step period minus one, in clk cycles.
REQ-008 dp_busy  in  1  bound-flasher datapath reports a sequence in progress (LEDs not all off).
REQ-009 step_en  out  1  one-cycle pulse; datapath advances one LED step only when high.
REQ-010 flick  out  1  clean flick level to the datapath, held until consumed by a step_en.
REQ-011 run_cnt  out  CNT_W  count of completed flasher sequences, saturating.
REQ-012 arm_err  out  1  sticky flag: datapath failed to start after a flick.
REQ-013 state  out  2  FSM state: IDLE=0, ARM=1, RUN=2, DONE=3.

Function
REQ-014 btn_in SHALL pass a 2-flop synchronizer, then a debouncer updating btn_db only after DEB_LEN consecutive identical synchronized samples.
REQ-015 A rising edge of btn_db SHALL create a one-cycle flick_req; falling edges SHALL be ignored.
REQ-016 presc_div SHALL be latched into div_q on every IDLE->ARM transition; changes during ARM/RUN/DONE SHALL be ignored.
REQ-017 Prescaler SHALL count 0..div_q in ARM and RUN, assert step_en in the cycle count==div_q, then wrap to 0; div_q=0 gives step_en every cycle.
REQ-018 In IDLE and DONE the prescaler SHALL be held at 0 and step_en SHALL be 0.
REQ-019 IDLE: on flick_req go to ARM, set flick=1 the next cycle.
REQ-020 flick SHALL fall in the cycle after any cycle with step_en=1 and flick=1; flick_req arriving while flick=1 SHALL merge (no extra pulse).
REQ-021 flick_req coincident with a consuming step_en SHALL leave flick=1 for the following step period (re-arm wins over clear).
REQ-022 ARM: dp_busy=1 -> RUN; ARM_STEPS step_en pulses without dp_busy -> IDLE with arm_err=1.
REQ-023 RUN: flick_req SHALL set flick=1 (kickback request); dp_busy=0 sampled -> DONE.
REQ-024 DONE lasts exactly one cycle; run_cnt += 1, saturating at 2^CNT_W-1; next state IDLE.
REQ-025 arm_err SHALL clear only on reset or on the next successful ARM->RUN transition.
REQ-026 flick_req in ARM SHALL behave as in RUN (REQ-023); in DONE it SHALL be dropped.

Reset
REQ-027 With rst_n=0 at a clk edge: state=IDLE, step_en=0, flick=0, run_cnt=0, arm_err=0, prescaler=0, div_q=0, synchronizer/debouncer/btn_db=0.
REQ-028 Reset mid-RUN SHALL abort in the same edge without incrementing run_cnt; no step_en after reset until a new flick_req.

Structure
REQ-029 State encoding and default parameter values SHALL live in shared package flasher_pkg.
REQ-030 Synchronizer plus debouncer plus edge detect SHALL be sub-module btn_debounce (in btn_in, out flick_req).
REQ-031 FSM, prescaler and counters SHALL be in flasher_ctrl; no gated clocks, no latches.

Verification (clk 10 ns, DEB_LEN=4, ARM_STEPS=4)
REQ-032 Reset 2 cycles, btn_in high 60 ns with 3 glitches <20 ns first -> exactly one flick_req; flick high until first step_en; state IDLE->ARM.
REQ-033 presc_div=3, dp_busy rises 2 steps after flick, falls 30 steps later -> step_en every 4th cycle, state RUN then DONE for 1 cycle, run_cnt=1.
REQ-034 presc_div=0, dp_busy held 0 after flick -> 4 step_en pulses then IDLE, arm_err=1; next successful start clears arm_err.
REQ-035 In RUN, button press completing on the same cycle as a consuming step_en -> flick stays 1 through the next step_en, then 0.
REQ-036 presc_div changed 3->7 mid-RUN -> step spacing stays 4 cycles; 256 completed runs with CNT_W=8 -> run_cnt saturates at 255; rst_n=0 mid-RUN -> all outputs 0, state IDLE next edge.
